// File: rtl/rs_syndrome_bank.sv
// rs_syndrome_bank: P-symbol-parallel Horner evaluation of NSYM Reed-Solomon syndromes
// over GF(2^10) (x^10+x^3+1), with frame-length checking and a valid/ready result stage.
module rs_syndrome_bank #(
    parameter int NSYM       = 22,
    parameter int P          = 32,
    parameter int N          = 544,
    parameter int FIRST_ROOT = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_last_i,
    input  logic [P-1:0][9:0]    in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NSYM-1:0][9:0] out_syn_o,
    output logic                 out_zero_o,
    output logic                 err_len_o
);
    localparam int SYM_W = 10;
    localparam int BEATS = N / P;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef logic [SYM_W-1:0]        sym_t;
    typedef logic [P-1:0][SYM_W-1:0] taps_t;
    typedef enum logic [0:0] {ACC, DISCARD} state_t;

    if (N % P != 0) begin : g_len_check
        $error("rs_syndrome_bank: N must be a multiple of P");
    end

    function automatic sym_t gf_mulx(input sym_t a);
        return {a[8:0], 1'b0} ^ (a[9] ? 10'h009 : 10'h000);
    endfunction

    // Shift-and-add product; with one operand constant this folds to an XOR network.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t r;
        sym_t s;
        r = '0;
        s = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) r = r ^ s;
            s = gf_mulx(s);
        end
        return r;
    endfunction

    function automatic sym_t gf_pow(input int e);
        sym_t r;
        r = 10'h001;
        for (int i = 0; i < e; i++) r = gf_mulx(r);
        return r;
    endfunction

    // Lane m carries the symbol of degree P-1-m within the beat.
    function automatic taps_t tap_table(input sym_t root);
        taps_t t;
        t[P-1] = 10'h001;
        for (int m = P - 2; m >= 0; m--) t[m] = gf_mul(t[m+1], root);
        return t;
    endfunction

    state_t                      state, state_next;
    logic [CNT_W-1:0]            beat_cnt, cnt_next;
    logic                        accept, good, err_set, last_slot;
    logic [NSYM-1:0][SYM_W-1:0]  acc_p0, acc_next, syn_p1;
    logic                        vld_p1, zero_p1, err_p1;

    assign last_slot = (beat_cnt == LAST_CNT);

    for (genvar j = 0; j < NSYM; j++) begin : g_syn
        localparam sym_t  ROOT = gf_pow(FIRST_ROOT + j);
        localparam taps_t TAPS = tap_table(ROOT);
        localparam sym_t  FB   = gf_mul(TAPS[0], ROOT);
        sym_t nxt;

        always_comb begin
            nxt = (beat_cnt == '0) ? '0 : gf_mul(acc_p0[j], FB);
            for (int m = 0; m < P; m++) nxt = nxt ^ gf_mul(in_data_i[m], TAPS[m]);
        end

        assign acc_next[j] = nxt;
    end

    always_comb begin
        state_next = state;
        cnt_next   = beat_cnt;
        good       = 1'b0;
        err_set    = 1'b0;
        in_ready_o = !(state == ACC && last_slot && vld_p1 && !out_ready_i);
        accept     = in_valid_i && in_ready_o;
        case (state)
            ACC: begin
                if (accept) begin
                    if (in_last_i) begin
                        cnt_next = '0;
                        if (last_slot) good = 1'b1;
                        else           err_set = 1'b1;
                    end else if (last_slot) begin
                        cnt_next   = '0;
                        err_set    = 1'b1;
                        state_next = DISCARD;
                    end else begin
                        cnt_next = beat_cnt + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (accept && in_last_i) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ACC;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= cnt_next;
        end
    end

    // Stage 0: per-syndrome accumulators
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_p0 <= '0;
        end else if (accept && state == ACC) begin
            acc_p0 <= acc_next;
        end
    end

    // Stage 1: result register behind valid/ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1  <= 1'b0;
            syn_p1  <= '0;
            zero_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            err_p1 <= err_set;
            if (good) begin
                vld_p1  <= 1'b1;
                syn_p1  <= acc_next;
                zero_p1 <= ~|acc_next;
            end else if (out_ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid_o = vld_p1;
    assign out_syn_o   = syn_p1;
    assign out_zero_o  = zero_p1;
    assign err_len_o   = err_p1;

endmodule
